ref_mem_ctrl_param: RTL
=======================

// Module: ref_mem_ctrl_param
// PURPOSE
// Parametrised reference-memory controller for the ME search window. LOAD phase fills
// NUM_BANKS banks in groups of GROUP banks, ROWS rows per group, under a valid/ready beat
// handshake. READ phase then sweeps the stored rows for RD_PASSES sub-areas, emitting
// rd_addr and rdr_sel to the PE array. It sits between the reference fetch path and the
// ref bank array. Adds start/busy/done/abort control and bank/row generalisation.
// PARAMETERS
// NUM_BANKS  32  total ref banks; must be a multiple of GROUP
// GROUP      4   banks written together per group (NUM_GROUPS = NUM_BANKS/GROUP)
// ROWS       96  rows per bank per group (load) and per pass (read)
// ADDR_W     7   row address width; ADDR_W >= clog2(ROWS)
// RD_PASSES  16  read sub-area passes; SEL_W = max(1, clog2(RD_PASSES))
// PORTS
// clk            in   1                   clock
// rst_n          in   1                   async active-low reset
// begin_prepare  in   1                   start pulse; sampled only in IDLE
// abort          in   1                   synchronous abort, any state
// wr_valid       in   1                   fetch beat available
// wr_ready       out  1                   high in LOAD (combinational from state)
// rd_ready       in   1                   consumer accepts a read row this cycle
// bank_sel       out  NUM_BANKS           write-enable mask for current group
// wr_addr        out  ADDR_W              row address broadcast to selected banks
// wr_en          out  1                   write strobe for bank_sel/wr_addr
// rd_en          out  1                   read strobe
// rd_addr        out  ADDR_W              read row address, all banks
// rdr_sel        out  SEL_W               current read pass / sub-area index
// busy           out  1                   state != IDLE
// done           out  1                   one-cycle pulse on completion
// BEHAVIOUR
// - Reset: clk domain only; rst_n low asynchronously forces state=IDLE and every output
//   and counter to 0. Reset mid-operation discards all progress; no done.
// - FSM: IDLE -> LOAD on begin_prepare (abort low). LOAD -> READ the cycle after the
//   last beat is accepted (group NUM_GROUPS-1, row ROWS-1). READ -> DONE after the last
//   read (pass RD_PASSES-1, row ROWS-1). DONE -> IDLE unconditionally after 1 cycle.
// - abort high: next state IDLE, counters cleared, wr_en/rd_en/done 0 next cycle.
//   abort wins over begin_prepare and over a simultaneous last beat.
// - begin_prepare outside IDLE is ignored.
// - LOAD beat accepted when wr_valid && wr_ready. One cycle later (registered):
//   wr_en=1, bank_sel = {GROUP{1'b1}} << (g*GROUP), wr_addr = r, where (g,r) are the
//   group/row of the accepted beat. No beat: wr_en=0, bank_sel=0, wr_addr holds.
//   r wraps ROWS-1 -> 0 with g+1. Last beat's wr_en may coincide with first READ cycle.
// - READ: when rd_ready high, next cycle rd_en=1, rd_addr=r, rdr_sel=p; r wraps
//   ROWS-1 -> 0 with p+1. rd_ready low: rd_en=0, rd_addr/rdr_sel hold.
// - done=1 only in DONE state; busy=1 in LOAD, READ, DONE.
// - Counters sized clog2 of their limit; no arithmetic overflow at defaults
//   (768 load beats, 1536 read rows).
// TESTING
// - Reset then begin_prepare, wr_valid=1 continuous -> 768 wr_en pulses; beat 0
//   bank_sel=0x0000000F addr 0; beat 96 0x000000F0 addr 0; beat 767 0xF0000000 addr 95.
// - Continue with rd_ready=1 -> 1536 rd_en pulses, rdr_sel 0..15, rd_addr 0..95 per pass,
//   done high exactly 1 cycle after last rd_en, then busy=0.
// - wr_valid/rd_ready toggled every other cycle -> same address sequence, no skipped or
//   duplicated rows; strobes low on idle cycles.
// - abort at load beat 200 -> busy=0 next cycle, no done; new begin_prepare restarts at
//   group 0 row 0. begin_prepare pulses during READ -> ignored.
// - rst_n low mid-READ -> all outputs 0 immediately; clean restart after release.
// - NUM_BANKS=16, GROUP=2, ROWS=8, RD_PASSES=4 -> 64 beats (last bank_sel=0xC000),
//   32 reads with rdr_sel 0..3, done once.

Source files
------------

// File: rtl/ref_mem_ctrl_param.sv
// Reference-memory controller for the motion-estimation search window.
// Loads bank groups from the fetch path, then sweeps stored rows per read pass.
module ref_mem_ctrl_param #(
    parameter int NUM_BANKS = 32,
    parameter int GROUP     = 4,
    parameter int ROWS      = 96,
    parameter int ADDR_W    = 7,
    parameter int RD_PASSES = 16,
    localparam int SEL_W    = (RD_PASSES > 1) ? $clog2(RD_PASSES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 begin_prepare,
    input  logic                 abort,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 rd_ready,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [SEL_W-1:0]     rdr_sel,
    output logic                 busy,
    output logic                 done
);
    localparam int NUM_GROUPS = NUM_BANKS / GROUP;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [ADDR_W-1:0]    ROW_LAST  = ADDR_W'(ROWS - 1);
    localparam logic [GRP_W-1:0]     GRP_LAST  = GRP_W'(NUM_GROUPS - 1);
    localparam logic [SEL_W-1:0]     PASS_LAST = SEL_W'(RD_PASSES - 1);
    localparam logic [NUM_BANKS-1:0] GRP_ONES  = NUM_BANKS'({GROUP{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [GRP_W-1:0]     grp_q;
    logic [ADDR_W-1:0]    wrow_q;
    logic [ADDR_W-1:0]    rrow_q;
    logic [SEL_W-1:0]     pass_q;
    logic                 fin_q;

    logic                 wr_en_q;
    logic [NUM_BANKS-1:0] bank_sel_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [SEL_W-1:0]     rdr_sel_q;
    logic                 done_q;

    logic [NUM_BANKS-1:0] bank_sel_d;
    logic [ADDR_W-1:0]    wrow_d;
    logic [ADDR_W-1:0]    rrow_d;
    logic                 wrow_last;
    logic                 rrow_last;

    assign bank_sel_d = GRP_ONES << (int'(grp_q) * GROUP);
    assign wrow_last  = (wrow_q == ROW_LAST);
    assign rrow_last  = (rrow_q == ROW_LAST);
    assign wrow_d     = wrow_last ? '0 : wrow_q + ADDR_W'(1);
    assign rrow_d     = rrow_last ? '0 : rrow_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grp_q      <= '0;
            wrow_q     <= '0;
            rrow_q     <= '0;
            pass_q     <= '0;
            fin_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            bank_sel_q <= '0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rdr_sel_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            bank_sel_q <= '0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                grp_q   <= '0;
                wrow_q  <= '0;
                rrow_q  <= '0;
                pass_q  <= '0;
                fin_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (begin_prepare) begin
                            state_q <= S_LOAD;
                            grp_q   <= '0;
                            wrow_q  <= '0;
                            rrow_q  <= '0;
                            pass_q  <= '0;
                            fin_q   <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (wr_valid) begin
                            wr_en_q    <= 1'b1;
                            bank_sel_q <= bank_sel_d;
                            wr_addr_q  <= wrow_q;
                            wrow_q     <= wrow_d;
                            if (wrow_last) begin
                                if (grp_q == GRP_LAST) begin
                                    grp_q   <= '0;
                                    state_q <= S_READ;
                                end else begin
                                    grp_q <= grp_q + GRP_W'(1);
                                end
                            end
                        end
                    end
                    S_READ: begin
                        // fin_q delays DONE one cycle so done follows the last rd_en
                        if (fin_q) begin
                            fin_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (rd_ready) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rrow_q;
                            rdr_sel_q <= pass_q;
                            rrow_q    <= rrow_d;
                            if (rrow_last) begin
                                if (pass_q == PASS_LAST) begin
                                    pass_q <= '0;
                                    fin_q  <= 1'b1;
                                end else begin
                                    pass_q <= pass_q + SEL_W'(1);
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign wr_en    = wr_en_q;
    assign bank_sel = bank_sel_q;
    assign wr_addr  = wr_addr_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign rdr_sel  = rdr_sel_q;
    assign done     = done_q;

endmodule
